// File: rtl/mdu_sequencer.sv
// mdu_sequencer: EX-stage controller for the multi-cycle RV32M unit.
// Latches an M-op on a cache miss, pulses M_START once, stalls EX until the
// unit reports M_READY, and keeps a one-entry {FUN3,RS1,RS2}->result cache.
// Ports:
//   CLK, RST (async, active-low), CACHE_READY (global enable)
//   REQ_VALID, FLUSH_I, FUN3, RS1, RS2 : request from EX
//   M_START, M_CNT, M_RS1, M_RS2       : command to the unit
//   M_OUT, M_READY                     : response from the unit
//   RESULT, RESULT_VALID, STALL        : back to EX
//   BUSY, ERR                          : status (ERR pulses on timeout)
module mdu_sequencer #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CACHE_READY,
    input  logic        REQ_VALID,
    input  logic        FLUSH_I,
    input  logic [2:0]  FUN3,
    input  logic [31:0] RS1,
    input  logic [31:0] RS2,
    output logic        M_START,
    output logic [2:0]  M_CNT,
    output logic [31:0] M_RS1,
    output logic [31:0] M_RS2,
    input  logic [31:0] M_OUT,
    input  logic        M_READY,
    output logic [31:0] RESULT,
    output logic        RESULT_VALID,
    output logic        STALL,
    output logic        BUSY,
    output logic        ERR
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ISSUE = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] DONE  = 3'd3;
    localparam logic [2:0] DRAIN = 3'd4;

    logic [2:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             cache_valid;
    logic [66:0]      tag;
    logic [31:0]      cache_data;
    logic             req, hit, timeout, capture;

    assign req     = REQ_VALID && !FLUSH_I;
    assign hit     = cache_valid && tag == {FUN3, RS1, RS2};
    assign timeout = CACHE_READY && state == WAIT && !M_READY && !FLUSH_I
                     && cnt == CNT_W'(TIMEOUT - 1);
    assign capture = state == WAIT && !FLUSH_I && M_READY;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = (req && !hit) ? ISSUE : IDLE;
            ISSUE:   state_nxt = FLUSH_I ? IDLE : WAIT;
            WAIT:    state_nxt = FLUSH_I ? (M_READY ? IDLE : DRAIN) :
                                 M_READY ? DONE : timeout ? IDLE : WAIT;
            DONE:    state_nxt = IDLE;
            DRAIN:   state_nxt = M_READY ? IDLE : DRAIN;
            default: state_nxt = IDLE;
        endcase
    end

    // Combinational outputs are gated by RST so they read 0 the moment reset asserts.
    assign M_START      = RST && CACHE_READY && state == ISSUE && !FLUSH_I;
    assign RESULT_VALID = RST && ((state == IDLE && req && hit) || state == DONE);
    assign RESULT       = RESULT_VALID ? cache_data : 32'd0;
    assign STALL        = RST && ((state == IDLE && req && !hit) ||
                                  ((state == ISSUE || state == WAIT) && !FLUSH_I && !timeout) ||
                                  (state == DRAIN && REQ_VALID));
    assign BUSY         = state != IDLE;
    assign ERR          = RST && timeout;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            cnt         <= '0;
            cache_valid <= 1'b0;
            tag         <= '0;
            cache_data  <= '0;
            M_CNT       <= '0;
            M_RS1       <= '0;
            M_RS2       <= '0;
        end else if (CACHE_READY) begin
            state <= state_nxt;
            cnt   <= state == WAIT ? cnt + CNT_W'(1) : '0;
            if (state == IDLE && req && !hit) begin
                M_CNT <= FUN3;
                M_RS1 <= RS1;
                M_RS2 <= RS2;
            end
            if (capture) begin
                cache_valid <= 1'b1;
                tag         <= {M_CNT, M_RS1, M_RS2};
                cache_data  <= M_OUT;
            end else if (timeout) begin
                cache_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Controller sitting between the EX stage and the multi-cycle RV32M multiply/divide unit.
- Accepts M-extension requests from EX and latches their operands.
- Issues a one-cycle start pulse, waits for unit ready, and generates the EX stall.
- Handles flush kills of in-flight operations and keeps a one-entry result cache, so an identical re-presented operation completes without re-running the unit.

Parameters:
TIMEOUT, 64, max cycles in WAIT before the op is abandoned and ERR is pulsed.
CNT_W, 7, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
CLK  in  1  clock, rising edge.
RST  in  1  asynchronous, active-low reset (0 = reset).
CACHE_READY  in  1  global pipeline enable; when 0, FSM, counter and registers hold.
REQ_VALID  in  1  EX holds an M-op (ALU_CNT==alu_mstd).
FLUSH_I  in  1  EX kill of the current/in-flight op.
FUN3  in  3  M-op select.
RS1  in  32  operand 1.
RS2  in  32  operand 2.
M_START  out  1  start pulse to RV32M.
M_CNT  out  3  latched FUN3 to unit.
M_RS1  out  32  latched RS1 to unit.
M_RS2  out  32  latched RS2 to unit.
M_OUT  in  32  unit result.
M_READY  in  1  unit done; level, held until next M_START.
RESULT  out  32  result to EX writeback mux.
RESULT_VALID  out  1  RESULT valid this cycle.
STALL  out  1  EX must hold (maps to EXSTAGE_STALLED).
BUSY  out  1  FSM not IDLE.
ERR  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset (RST=0, asynchronous):
  - state=IDLE, cache invalid, counter=0.
  - All outputs 0; M_CNT, M_RS1, M_RS2 = 0.
- States: IDLE, ISSUE, WAIT, DONE, DRAIN. All transitions require CACHE_READY=1; otherwise state holds and M_START=0.
- Cache hit: cache valid and {FUN3,RS1,RS2} equals the stored tag.
- IDLE:
  - REQ_VALID & !FLUSH_I & hit: RESULT=cached value, RESULT_VALID=1, STALL=0, same cycle (combinational); stay IDLE.
  - REQ_VALID & !FLUSH_I & miss: STALL=1 combinationally; latch FUN3/RS1/RS2 into M_*; next state ISSUE.
  - REQ_VALID & FLUSH_I: ignored, STALL=0.
- ISSUE: M_START=1 for exactly one cycle, STALL=1; next WAIT, counter=0. FLUSH_I here: M_START=0, go IDLE, no unit activity.
- WAIT: STALL=1, counter increments each enabled cycle.
  - M_READY: capture M_OUT into result reg and cache; tag := latched operands; valid=1; go DONE.
  - FLUSH_I (including same cycle as M_READY): discard, cache unchanged, STALL=0. Go DRAIN, or IDLE if M_READY is already 1.
  - counter==TIMEOUT-1 without M_READY: ERR=1 for one cycle, cache invalidated, go IDLE, STALL=0, RESULT_VALID=0.
- DONE: STALL=0, RESULT_VALID=1, RESULT=result reg; go IDLE. Latency from request to RESULT_VALID is 3 + unit cycles.
- DRAIN: STALL=0 for the killed op; wait for M_READY, then go IDLE, result discarded. A new REQ_VALID in DRAIN gets STALL=1 and no latch; it is re-evaluated in IDLE.
- M_START is never asserted while BUSY from a prior un-ready op, so at most one op is outstanding.
- RESULT=0 whenever RESULT_VALID=0.
- Reset mid-operation: immediate return to IDLE, cache invalid; the unit is restarted fresh by the next request.

Test Plan:
- MUL, RS1=7, RS2=6, unit latency 4 → M_START one cycle after request; STALL high 6 cycles; DONE gives RESULT=42, RESULT_VALID=1 for one cycle.
- Same MUL 7×6 re-presented in IDLE → RESULT=42 in the same cycle; STALL=0; no M_START.
- DIV 100/7, FLUSH_I asserted 2 cycles into WAIT → STALL drops; DRAIN until M_READY; no RESULT_VALID; cache unchanged; a next DIV 100/7 re-runs the unit, result 14.
- CACHE_READY=0 for 3 cycles during ISSUE → M_START deferred until re-enable, fires once; final result correct.
- M_READY held low, TIMEOUT=64 → ERR pulse after 64 WAIT cycles; STALL deasserts; BUSY=0; cache invalid.
- RST low during WAIT → all outputs 0 asynchronously; after release the first request misses the cache and issues normally.
